// File: rtl/tlb_op_sequencer.sv
// -----------------------------------------------------------------------------
// tlb_op_sequencer
// Runs the CP0 TLB instructions (TLBR, TLBWI, TLBWR, TLBP) as multi-cycle
// operations between the execute stage and the TLB entry array. It holds off
// the pipeline through op_ready, packs and unpacks the 90-bit TLB entry, returns
// CP0 register updates and keeps the Random register counting.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   op_valid/op_code/op_ready   request handshake (00 TLBR, 01 TLBWI, 10 TLBWR, 11 TLBP)
//   op_done                     one-cycle completion pulse
//   index_i..pagemask_i         CP0 register values, captured when a request is accepted
//   wired_i, wired_we           CP0 Wired value and its write strobe
//   random_o                    current Random value
//   tlb_we/tlb_waddr/tlb_wdata  entry array write port
//   tlb_raddr/tlb_rdata         entry array read port (data one cycle after address)
//   index_we, index_o           Index write-back (TLBP result)
//   rd_we, entryhi_o..pagemask_o  EntryHi/EntryLo0/EntryLo1/PageMask write-back (TLBR)
// -----------------------------------------------------------------------------
module tlb_op_sequencer #(
   parameter int TLB_ENTRIES = 16,
   parameter int IDX_W       = $clog2(TLB_ENTRIES)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             op_valid,
   input  logic [1:0]       op_code,
   output logic             op_ready,
   output logic             op_done,
   input  logic [31:0]      index_i,
   input  logic [31:0]      entryhi_i,
   input  logic [31:0]      entrylo0_i,
   input  logic [31:0]      entrylo1_i,
   input  logic [31:0]      pagemask_i,
   input  logic [IDX_W-1:0] wired_i,
   input  logic             wired_we,
   output logic [IDX_W-1:0] random_o,
   output logic             tlb_we,
   output logic [IDX_W-1:0] tlb_waddr,
   output logic [89:0]      tlb_wdata,
   output logic [IDX_W-1:0] tlb_raddr,
   input  logic [89:0]      tlb_rdata,
   output logic             index_we,
   output logic [31:0]      index_o,
   output logic             rd_we,
   output logic [31:0]      entryhi_o,
   output logic [31:0]      entrylo0_o,
   output logic [31:0]      entrylo1_o,
   output logic [31:0]      pagemask_o
);

   localparam logic [IDX_W-1:0] LAST = IDX_W'(TLB_ENTRIES - 1);
   localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);

   typedef enum logic [2:0] {
      S_IDLE, S_RD_ADDR, S_RD_DATA, S_WRITE, S_PROBE, S_DONE_P
   } state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W-1:0] idx_snap_q, idx_snap_d;
   logic [18:0]      vpn2_q, vpn2_d;
   logic [7:0]       asid_q, asid_d;
   logic [IDX_W-1:0] waddr_q, waddr_d;
   logic [89:0]      wdata_q, wdata_d;
   logic [IDX_W-1:0] random_q, random_d;
   logic             op_done_q, op_done_d;
   logic             tlb_we_q, tlb_we_d;
   logic             rd_we_q, rd_we_d;
   logic             index_we_q, index_we_d;
   logic [31:0]      index_q, index_d;
   logic [31:0]      eh_hold_q, eh_hold_d;
   logic [31:0]      lo0_hold_q, lo0_hold_d;
   logic [31:0]      lo1_hold_q, lo1_hold_d;
   logic [31:0]      pm_hold_q, pm_hold_d;

   logic [89:0]      enc_entry;
   logic [IDX_W-1:0] cmp_idx;
   logic             probe_hit;

   // Bits of the CP0 registers that have no home in a TLB entry.
   logic unused_bits;
   assign unused_bits = ^{index_i[31:IDX_W], entryhi_i[12:8], entrylo0_i[31:26],
                          entrylo1_i[31:26], pagemask_i[31:25], pagemask_i[12:0]};

   assign enc_entry = {entryhi_i[31:13], entryhi_i[7:0], pagemask_i[24:13],
                       entrylo0_i[0] & entrylo1_i[0],
                       entrylo0_i[25:6], entrylo0_i[5:1],
                       entrylo1_i[25:6], entrylo1_i[5:1]};

   // The probe pointer is kept at 0 whenever the FSM is idle, so entry 0 is
   // already being read in the accept cycle; PROBE then compares entry ptr-1.
   assign cmp_idx   = ptr_q - ONE;
   assign probe_hit = (tlb_rdata[89:71] == vpn2_q) &&
                      ((tlb_rdata[70:63] == asid_q) || tlb_rdata[50]);

   assign op_ready  = (state_q == S_IDLE);
   assign op_done   = op_done_q;
   assign tlb_we    = tlb_we_q;
   assign tlb_waddr = waddr_q;
   assign tlb_wdata = wdata_q;
   assign tlb_raddr = (state_q == S_RD_ADDR) ? idx_snap_q : ptr_q;
   assign index_we  = index_we_q;
   assign index_o   = index_q;
   assign rd_we     = rd_we_q;
   assign random_o  = random_q;

   // Read data only arrives in the RD_DATA cycle, so the decoded view is shown
   // directly then and held in registers afterwards.
   assign entryhi_o  = rd_we_q ? {tlb_rdata[89:71], 5'b0, tlb_rdata[70:63]} : eh_hold_q;
   assign pagemask_o = rd_we_q ? {7'b0, tlb_rdata[62:51], 13'b0} : pm_hold_q;
   assign entrylo0_o = rd_we_q ? {6'b0, tlb_rdata[49:25], tlb_rdata[50]} : lo0_hold_q;
   assign entrylo1_o = rd_we_q ? {6'b0, tlb_rdata[24:0], tlb_rdata[50]} : lo1_hold_q;

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      idx_snap_d = idx_snap_q;
      vpn2_d     = vpn2_q;
      asid_d     = asid_q;
      waddr_d    = waddr_q;
      wdata_d    = wdata_q;
      index_d    = index_q;
      op_done_d  = 1'b0;
      tlb_we_d   = 1'b0;
      rd_we_d    = 1'b0;
      index_we_d = 1'b0;
      eh_hold_d  = entryhi_o;
      lo0_hold_d = entrylo0_o;
      lo1_hold_d = entrylo1_o;
      pm_hold_d  = pagemask_o;

      // Random counts down to Wired and reloads; a Wired write restarts it.
      if (wired_we || (random_q == wired_i) || (wired_i >= LAST))
         random_d = LAST;
      else
         random_d = random_q - ONE;

      case (state_q)
         S_IDLE: begin
            if (op_valid) begin
               idx_snap_d = index_i[IDX_W-1:0];
               vpn2_d     = entryhi_i[31:13];
               asid_d     = entryhi_i[7:0];
               case (op_code)
                  2'b00: state_d = S_RD_ADDR;
                  2'b01, 2'b10: begin
                     state_d   = S_WRITE;
                     tlb_we_d  = 1'b1;
                     op_done_d = 1'b1;
                     waddr_d   = op_code[1] ? random_q : index_i[IDX_W-1:0];
                     wdata_d   = enc_entry;
                  end
                  default: begin
                     state_d = S_PROBE;
                     ptr_d   = ONE;
                  end
               endcase
            end
         end
         S_RD_ADDR: begin
            state_d   = S_RD_DATA;
            rd_we_d   = 1'b1;
            op_done_d = 1'b1;
         end
         S_PROBE: begin
            if (probe_hit || (cmp_idx == LAST)) begin
               state_d    = S_DONE_P;
               ptr_d      = '0;
               index_we_d = 1'b1;
               op_done_d  = 1'b1;
               index_d    = probe_hit ? {{(32-IDX_W){1'b0}}, cmp_idx} : 32'h8000_0000;
            end else begin
               ptr_d = ptr_q + ONE;
            end
         end
         default: state_d = S_IDLE;  // RD_DATA, WRITE, DONE_P
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         ptr_q      <= '0;
         idx_snap_q <= '0;
         vpn2_q     <= '0;
         asid_q     <= '0;
         waddr_q    <= '0;
         wdata_q    <= '0;
         random_q   <= LAST;
         op_done_q  <= 1'b0;
         tlb_we_q   <= 1'b0;
         rd_we_q    <= 1'b0;
         index_we_q <= 1'b0;
         index_q    <= '0;
         eh_hold_q  <= '0;
         lo0_hold_q <= '0;
         lo1_hold_q <= '0;
         pm_hold_q  <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         idx_snap_q <= idx_snap_d;
         vpn2_q     <= vpn2_d;
         asid_q     <= asid_d;
         waddr_q    <= waddr_d;
         wdata_q    <= wdata_d;
         random_q   <= random_d;
         op_done_q  <= op_done_d;
         tlb_we_q   <= tlb_we_d;
         rd_we_q    <= rd_we_d;
         index_we_q <= index_we_d;
         index_q    <= index_d;
         eh_hold_q  <= eh_hold_d;
         lo0_hold_q <= lo0_hold_d;
         lo1_hold_q <= lo1_hold_d;
         pm_hold_q  <= pm_hold_d;
      end
   end

endmodule

// File: tb/tb_tlb_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_tlb_op_sequencer
// Directed bench for tlb_op_sequencer with a 16-entry TLB array model
// (registered read). Inputs are driven just after the falling edge, outputs
// are sampled on the falling edge. Prints one line per TLB operation.
// -----------------------------------------------------------------------------
module tb_tlb_op_sequencer;

   localparam int N = 16;
   localparam int W = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          op_valid = 1'b0;
   logic [1:0]    op_code = 2'b00;
   logic          op_ready, op_done;
   logic [31:0]   index_i = '0, entryhi_i = '0, entrylo0_i = '0, entrylo1_i = '0, pagemask_i = '0;
   logic [W-1:0]  wired_i = '0;
   logic          wired_we = 1'b0;
   logic [W-1:0]  random_o;
   logic          tlb_we;
   logic [W-1:0]  tlb_waddr, tlb_raddr;
   logic [89:0]   tlb_wdata;
   logic [89:0]   tlb_rdata;
   logic          index_we, rd_we;
   logic [31:0]   index_o, entryhi_o, entrylo0_o, entrylo1_o, pagemask_o;

   logic [89:0]   mem [N];

   int n_checks = 0;
   int n_err    = 0;

   // Values captured in the op_done cycle
   int           done_cyc;
   int           stray;
   logic         c_tlb_we, c_rd_we, c_index_we;
   logic [W-1:0] c_waddr;
   logic [89:0]  c_wdata;
   logic [31:0]  c_index, c_eh, c_lo0, c_lo1, c_pm;

   always #5 clk = ~clk;

   tlb_op_sequencer #(.TLB_ENTRIES(N)) dut (
      .clk(clk), .rst(rst),
      .op_valid(op_valid), .op_code(op_code), .op_ready(op_ready), .op_done(op_done),
      .index_i(index_i), .entryhi_i(entryhi_i), .entrylo0_i(entrylo0_i),
      .entrylo1_i(entrylo1_i), .pagemask_i(pagemask_i),
      .wired_i(wired_i), .wired_we(wired_we), .random_o(random_o),
      .tlb_we(tlb_we), .tlb_waddr(tlb_waddr), .tlb_wdata(tlb_wdata),
      .tlb_raddr(tlb_raddr), .tlb_rdata(tlb_rdata),
      .index_we(index_we), .index_o(index_o),
      .rd_we(rd_we), .entryhi_o(entryhi_o), .entrylo0_o(entrylo0_o),
      .entrylo1_o(entrylo1_o), .pagemask_o(pagemask_o)
   );

   // TLB entry array model: synchronous write, registered read.
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N; i++) mem[i] <= '0;
      end else if (tlb_we) begin
         mem[tlb_waddr] <= tlb_wdata;
      end
      tlb_rdata <= mem[tlb_raddr];
   end

   task automatic check(input string tag, input logic [89:0] obs, input logic [89:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present a request (called just after a falling edge), wait for
   // acceptance, then scramble the inputs so only the snapshot can be used.
   task automatic issue(input logic [1:0] op, input logic [31:0] idx, input logic [31:0] eh,
                        input logic [31:0] lo0, input logic [31:0] lo1, input logic [31:0] pm);
      int guard;
      op_code    = op;
      index_i    = idx;
      entryhi_i  = eh;
      entrylo0_i = lo0;
      entrylo1_i = lo1;
      pagemask_i = pm;
      op_valid   = 1'b1;
      guard      = 0;
      while (!op_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check("ready", {89'b0, op_ready}, 90'd1);
      @(posedge clk);
      #1;
      op_valid   = 1'b0;
      op_code    = 2'b11;
      index_i    = 32'h0000_0009;
      entryhi_i  = 32'hDEAD_BEEF;
      entrylo0_i = 32'hFFFF_FFFF;
      entrylo1_i = 32'hFFFF_FFFF;
      pagemask_i = 32'h01FF_E000;
   endtask

   // Wait (bounded) for op_done, counting cycles after the accepting edge.
   task automatic run(input string name);
      done_cyc = 0;
      stray    = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (op_done) begin
            done_cyc   = k;
            c_tlb_we   = tlb_we;
            c_rd_we    = rd_we;
            c_index_we = index_we;
            c_waddr    = tlb_waddr;
            c_wdata    = tlb_wdata;
            c_index    = index_o;
            c_eh       = entryhi_o;
            c_lo0      = entrylo0_o;
            c_lo1      = entrylo1_o;
            c_pm       = pagemask_o;
            break;
         end
         if (tlb_we || rd_we || index_we) stray++;
      end
      $display("op %s: done after %0d cycles, index_o=%08h entryhi_o=%08h", name, done_cyc,
               index_o, entryhi_o);
      check({name, " stray"}, 90'(stray), 90'd0);
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      check("rst ready",  {89'b0, op_ready}, 90'd1);
      check("rst done",   {89'b0, op_done},  90'd0);
      check("rst we",     {89'b0, tlb_we},   90'd0);
      check("rst random", 90'(random_o),     90'd15);
      check("rst index",  90'(index_o),      90'd0);
      check("rst eh",     90'(entryhi_o),    90'd0);
      rst = 1'b0;
      @(negedge clk);

      // TLBWI at 3, G=1
      issue(2'b01, 32'd3, 32'h0040_2005, 32'h0000_1047, 32'h0000_1087, 32'h0);
      run("TLBWI3");
      check("wi cyc",   90'(done_cyc), 90'd1);
      check("wi we",    {89'b0, c_tlb_we}, 90'd1);
      check("wi waddr", 90'(c_waddr), 90'd3);
      check("wi wdata", c_wdata,
            {19'h00201, 8'h05, 12'h000, 1'b1, 20'h00041, 5'h03, 20'h00042, 5'h03});

      // TLBR of entry 3, issued back-to-back
      issue(2'b00, 32'd3, 32'h0, 32'h0, 32'h0, 32'h0);
      run("TLBR3");
      check("rd cyc", 90'(done_cyc), 90'd2);
      check("rd we",  {89'b0, c_rd_we}, 90'd1);
      check("rd eh",  90'(c_eh),  90'h0040_2005);
      check("rd lo0", 90'(c_lo0), 90'h0000_1047);
      check("rd lo1", 90'(c_lo1), 90'h0000_1087);
      check("rd pm",  90'(c_pm),  90'h0);
      @(negedge clk);
      check("rd hold eh", 90'(entryhi_o), 90'h0040_2005);

      // TLBWI at 7, G=0, non-zero mask
      issue(2'b01, 32'd7, 32'h0040_2005, 32'h0000_2046, 32'h0000_2086, 32'h0000_6000);
      run("TLBWI7");
      check("wi7 waddr", 90'(c_waddr), 90'd7);
      issue(2'b00, 32'd7, 32'h0, 32'h0, 32'h0, 32'h0);
      run("TLBR7");
      check("rd7 pm",  90'(c_pm),  90'h0000_6000);
      check("rd7 lo0", 90'(c_lo0), 90'h0000_2046);
      check("rd7 lo1", 90'(c_lo1), 90'h0000_2086);

      // Random sequence with Wired=4
      @(negedge clk);
      wired_i  = 4'd4;
      wired_we = 1'b1;
      @(negedge clk);
      wired_we = 1'b0;
      check("rnd load", 90'(random_o), 90'd15);
      for (int k = 2; k <= 12; k++) begin
         @(negedge clk);
         check("rnd dec", 90'(random_o), 90'(16 - k));
      end
      @(negedge clk);
      check("rnd wrap", 90'(random_o), 90'd15);

      // TLBWR: Random forced to 15 just before accept
      wired_i  = 4'd0;
      wired_we = 1'b1;
      @(negedge clk);
      wired_we = 1'b0;
      check("wr rnd", 90'(random_o), 90'd15);
      issue(2'b10, 32'd2, 32'h0080_0011, 32'h0000_0001, 32'h0000_0001, 32'h0);
      run("TLBWR");
      check("wr cyc",   90'(done_cyc), 90'd1);
      check("wr waddr", 90'(c_waddr), 90'd15);

      // TLBP hit: entries 3 and 7 both match, lowest wins
      issue(2'b11, 32'd0, 32'h0040_2005, 32'h0, 32'h0, 32'h0);
      run("TLBP hit3");
      check("p3 cyc",   90'(done_cyc), 90'd5);
      check("p3 we",    {89'b0, c_index_we}, 90'd1);
      check("p3 index", 90'(c_index), 90'd3);

      // Different ASID still hits entry 3 through G
      issue(2'b11, 32'd0, 32'h0040_2006, 32'h0, 32'h0, 32'h0);
      run("TLBP global");
      check("pg index", 90'(c_index), 90'd3);

      // Last entry
      issue(2'b11, 32'd0, 32'h0080_0011, 32'h0, 32'h0, 32'h0);
      run("TLBP hit15");
      check("p15 cyc",   90'(done_cyc), 90'd17);
      check("p15 index", 90'(c_index), 90'd15);

      // Clear G on entry 3, then probe a mismatching ASID: miss
      issue(2'b01, 32'd3, 32'h0040_2005, 32'h0000_1046, 32'h0000_1087, 32'h0);
      run("TLBWI3 G0");
      issue(2'b11, 32'd0, 32'h0040_2006, 32'h0, 32'h0, 32'h0);
      run("TLBP miss");
      check("pm cyc",   90'(done_cyc), 90'd17);
      check("pm we",    {89'b0, c_index_we}, 90'd1);
      check("pm index", 90'(c_index), 90'h8000_0000);

      // Reset during the second PROBE cycle
      issue(2'b11, 32'd0, 32'h0040_2005, 32'h0, 32'h0, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("mid rst strobes", {86'b0, op_done, index_we, tlb_we, rd_we}, 90'd0);
      check("mid rst index", 90'(index_o), 90'd0);
      check("mid rst random", 90'(random_o), 90'd15);
      rst = 1'b0;
      @(negedge clk);
      check("post rst ready", {89'b0, op_ready}, 90'd1);
      stray = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (op_done || index_we) stray++;
      end
      check("post rst quiet", 90'(stray), 90'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
